// File: rtl/cfg_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one half-width product, two independent
// half-width lanes, or one full-width product; signed or unsigned per transaction.
module cfg_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic [1:0]         cm_i,
  input  logic               signed_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [1:0]         state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and data is held while valid waits.

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] N_HALF  = CW'(H);
  localparam logic [CW-1:0] N_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q;
  logic [1:0]         cm_q;
  logic               sgn_q;
  logic               bf_msb_q;
  logic               bl_msb_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q, prod_d;
  logic               err_q;
  logic               last;

  // Accumulators carry two guard bits so +/-M never overflows for either signedness.
  logic [WIDTH+1:0] mf, sumf, accf_q, accf_d;
  logic [WIDTH-1:0] qf_q, qf_d;
  logic             qf1_q, qf1_d;
  logic [H+1:0]     mh, sumh, acch_q, acch_d;
  logic [H-1:0]     qh_q, qh_d;
  logic             qh1_q, qh1_d;
  logic [H+1:0]     ml, suml, accl_q, accl_d;
  logic [H-1:0]     ql_q, ql_d;
  logic             ql1_q, ql1_d;

  logic [WIDTH-1:0]   lo_p, hi_p;
  logic [2*WIDTH-1:0] full_p;

  assign last = (cnt_q == CNT_ONE);
  assign mf   = {{2{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mh   = {{2{sgn_q & a_q[WIDTH-1]}}, a_q[WIDTH-1:H]};
  assign ml   = {{2{sgn_q & a_q[H-1]}}, a_q[H-1:0]};

  // Booth steps treat the multiplier as two's complement; for unsigned operands the
  // extra zero-extension digit adds +M at weight 2^n, folded into the final step.
  always_comb begin
    case ({qf_q[0], qf1_q})
      2'b01:   sumf = accf_q + mf;
      2'b10:   sumf = accf_q - mf;
      default: sumf = accf_q;
    endcase
    accf_d = {sumf[WIDTH+1], sumf[WIDTH+1:1]};
    qf_d   = {sumf[0], qf_q[WIDTH-1:1]};
    qf1_d  = qf_q[0];
    if (last && !sgn_q && bf_msb_q) accf_d = accf_d + mf;
  end

  always_comb begin
    case ({qh_q[0], qh1_q})
      2'b01:   sumh = acch_q + mh;
      2'b10:   sumh = acch_q - mh;
      default: sumh = acch_q;
    endcase
    acch_d = {sumh[H+1], sumh[H+1:1]};
    qh_d   = {sumh[0], qh_q[H-1:1]};
    qh1_d  = qh_q[0];
    if (last && !sgn_q && bf_msb_q) acch_d = acch_d + mh;
  end

  always_comb begin
    case ({ql_q[0], ql1_q})
      2'b01:   suml = accl_q + ml;
      2'b10:   suml = accl_q - ml;
      default: suml = accl_q;
    endcase
    accl_d = {suml[H+1], suml[H+1:1]};
    ql_d   = {suml[0], ql_q[H-1:1]};
    ql1_d  = ql_q[0];
    if (last && !sgn_q && bl_msb_q) accl_d = accl_d + ml;
  end

  assign lo_p   = {accl_d[H-1:0], ql_d};
  assign hi_p   = {acch_d[H-1:0], qh_d};
  assign full_p = {accf_d[WIDTH-1:0], qf_d};

  always_comb begin
    prod_d = '0;
    case (cm_q)
      2'b00:   prod_d = sgn_q ? {{WIDTH{lo_p[WIDTH-1]}}, lo_p} : {{WIDTH{1'b0}}, lo_p};
      2'b01:   prod_d = {hi_p, lo_p};
      2'b10:   prod_d = full_p;
      default: prod_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = (cm_i == 2'b11) ? S_DONE : S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_o = 1'b1;
      S_CALC:  busy_o = 1'b1;
      S_DONE:  begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: in_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_q       <= '0;
      cm_q      <= '0;
      sgn_q     <= 1'b0;
      bf_msb_q  <= 1'b0;
      bl_msb_q  <= 1'b0;
      cnt_q     <= '0;
      accf_q    <= '0;
      qf_q      <= '0;
      qf1_q     <= 1'b0;
      acch_q    <= '0;
      qh_q      <= '0;
      qh1_q     <= 1'b0;
      accl_q    <= '0;
      ql_q      <= '0;
      ql1_q     <= 1'b0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid_i) begin
          a_q      <= multiplicand_i;
          cm_q     <= cm_i;
          sgn_q    <= signed_i;
          bf_msb_q <= multiplier_i[WIDTH-1];
          bl_msb_q <= multiplier_i[H-1];
          cnt_q    <= (cm_i == 2'b10) ? N_FULL : N_HALF;
          accf_q   <= '0;
          qf_q     <= multiplier_i;
          qf1_q    <= 1'b0;
          acch_q   <= '0;
          qh_q     <= multiplier_i[WIDTH-1:H];
          qh1_q    <= 1'b0;
          accl_q   <= '0;
          ql_q     <= multiplier_i[H-1:0];
          ql1_q    <= 1'b0;
          if (cm_i == 2'b11) begin
            product_q <= '0;
            err_q     <= 1'b1;
          end
        end
        S_CALC: begin
          accf_q <= accf_d;
          qf_q   <= qf_d;
          qf1_q  <= qf1_d;
          acch_q <= acch_d;
          qh_q   <= qh_d;
          qh1_q  <= qh1_d;
          accl_q <= accl_d;
          ql_q   <= ql_d;
          ql1_q  <= ql1_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (last) begin
            product_q <= prod_d;
            err_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign product_o = product_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule
